// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back stage and general-purpose register file.
//               Selects the write-back value from the MEM/WB register outputs,
//               commits it into a 32-entry register file, serves two ID-stage
//               read ports with same-cycle write-through bypass, and counts
//               committed writes.
// Ports       : clk          - clock, all state changes on the rising edge
//               rst          - synchronous reset, active low
//               wbIn         - WB control {regWrite, memToReg}
//               readDataIn   - data-memory read data from MEM/WB
//               resultIn     - ALU result from MEM/WB
//               registerRdIn - destination register index from MEM/WB
//               readReg1/2   - ID-stage source register indices
//               readData1/2  - source register values, bypass applied
//               wbData       - selected write-back value
//               wbEnable     - qualified write strobe
//               writeCount   - committed register writes since reset
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wbIn,
  input  logic [DATA_W-1:0] readDataIn,
  input  logic [DATA_W-1:0] resultIn,
  input  logic [ADDR_W-1:0] registerRdIn,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] wbData,
  output logic              wbEnable,
  output logic [31:0]       writeCount
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [31:0]       write_count;
  logic [DATA_W-1:0] wb_data;
  logic              wb_enable;

  // Write-back select and write qualification. Holding the strobe low in
  // reset also disables the bypass path, so reads see the cleared registers.
  always_comb begin
    wb_data   = wbIn[0] ? readDataIn : resultIn;
    wb_enable = wbIn[1] && (registerRdIn != ZERO_IDX) && rst;
  end

  // Register file and commit counter. Index 0 is never written since the
  // qualified strobe excludes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      write_count <= '0;
    end else if (wb_enable) begin
      regs[registerRdIn] <= wb_data;
      write_count        <= write_count + 32'd1;
    end
  end

  // Read ports: hard-wired zero for index 0, then same-cycle bypass of the
  // write being committed, then the stored value.
  always_comb begin
    if (readReg1 == ZERO_IDX) begin
      readData1 = '0;
    end else if (wb_enable && (readReg1 == registerRdIn)) begin
      readData1 = wb_data;
    end else begin
      readData1 = regs[readReg1];
    end

    if (readReg2 == ZERO_IDX) begin
      readData2 = '0;
    end else if (wb_enable && (readReg2 == registerRdIn)) begin
      readData2 = wb_data;
    end else begin
      readData2 = regs[readReg2];
    end
  end

  assign wbData     = wb_data;
  assign wbEnable   = wb_enable;
  assign writeCount = write_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Directed self-checking testbench for wb_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [1:0]  wbIn;
  logic [31:0] readDataIn;
  logic [31:0] resultIn;
  logic [4:0]  registerRdIn;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] wbData;
  logic        wbEnable;
  logic [31:0] writeCount;

  int checks;
  int failures;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wbIn         (wbIn),
    .readDataIn   (readDataIn),
    .resultIn     (resultIn),
    .registerRdIn (registerRdIn),
    .readReg1     (readReg1),
    .readReg2     (readReg2),
    .readData1    (readData1),
    .readData2    (readData2),
    .wbData       (wbData),
    .wbEnable     (wbEnable),
    .writeCount   (writeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; wbIn = 2'b10; registerRdIn = 5'd5; resultIn = 32'hDEAD;
    readDataIn = 32'h0; readReg1 = 5'd5; readReg2 = 5'd0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (readData1 !== 32'h0) begin failures++; $display("FAIL reset_reg5: got %h expected %h", readData1, 32'h0); end
    checks++; if (writeCount !== 32'h0) begin failures++; $display("FAIL reset_count: got %h expected %h", writeCount, 32'h0); end
    checks++; if (wbEnable !== 1'b0) begin failures++; $display("FAIL reset_wbenable: got %b expected 0", wbEnable); end
    checks++; if (wbData !== 32'hDEAD) begin failures++; $display("FAIL reset_wbdata: got %h expected %h", wbData, 32'hDEAD); end
    @(negedge clk);
    rst = 1'b1; wbIn = 2'b00;
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    wbIn = 2'b10; registerRdIn = 5'd8; resultIn = 32'h1234_5678; readDataIn = 32'h0;
    @(posedge clk); #1;
    wbIn = 2'b00; readReg1 = 5'd8; readReg2 = 5'd5; #1;
    checks++; if (readData1 !== 32'h1234_5678) begin failures++; $display("FAIL alu_read: got %h expected %h", readData1, 32'h1234_5678); end
    checks++; if (readData2 !== 32'h0) begin failures++; $display("FAIL alu_other_reg: got %h expected %h", readData2, 32'h0); end
    checks++; if (writeCount !== 32'd1) begin failures++; $display("FAIL alu_count: got %0d expected 1", writeCount); end
  endtask

  task automatic test_load_bypass();
    @(negedge clk);
    wbIn = 2'b11; registerRdIn = 5'd9; readDataIn = 32'hCAFE_F00D; resultIn = 32'h1;
    readReg1 = 5'd9; readReg2 = 5'd9; #1;
    checks++; if (wbData !== 32'hCAFE_F00D) begin failures++; $display("FAIL load_select: got %h expected %h", wbData, 32'hCAFE_F00D); end
    checks++; if (wbEnable !== 1'b1) begin failures++; $display("FAIL load_wbenable: got %b expected 1", wbEnable); end
    checks++; if (readData1 !== 32'hCAFE_F00D) begin failures++; $display("FAIL bypass_port1: got %h expected %h", readData1, 32'hCAFE_F00D); end
    checks++; if (readData2 !== 32'hCAFE_F00D) begin failures++; $display("FAIL bypass_port2: got %h expected %h", readData2, 32'hCAFE_F00D); end
    @(posedge clk); #1;
    wbIn = 2'b00; readReg2 = 5'd8; #1;
    checks++; if (readData1 !== 32'hCAFE_F00D) begin failures++; $display("FAIL load_stored: got %h expected %h", readData1, 32'hCAFE_F00D); end
    checks++; if (readData2 !== 32'h1234_5678) begin failures++; $display("FAIL load_port2_reg8: got %h expected %h", readData2, 32'h1234_5678); end
    checks++; if (writeCount !== 32'd2) begin failures++; $display("FAIL load_count: got %0d expected 2", writeCount); end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    wbIn = 2'b10; registerRdIn = 5'd0; resultIn = 32'hFFFF_FFFF; readReg1 = 5'd0; readReg2 = 5'd0; #1;
    checks++; if (wbEnable !== 1'b0) begin failures++; $display("FAIL reg0_wbenable: got %b expected 0", wbEnable); end
    checks++; if (readData1 !== 32'h0) begin failures++; $display("FAIL reg0_bypass: got %h expected %h", readData1, 32'h0); end
    @(posedge clk); #1;
    wbIn = 2'b00; #1;
    checks++; if (readData1 !== 32'h0) begin failures++; $display("FAIL reg0_read: got %h expected %h", readData1, 32'h0); end
    checks++; if (writeCount !== 32'd2) begin failures++; $display("FAIL reg0_count: got %0d expected 2", writeCount); end
  endtask

  task automatic test_no_write();
    @(negedge clk);
    wbIn = 2'b01; registerRdIn = 5'd8; readDataIn = 32'hBAD; readReg1 = 5'd8; #1;
    checks++; if (wbEnable !== 1'b0) begin failures++; $display("FAIL nowr_wbenable: got %b expected 0", wbEnable); end
    checks++; if (wbData !== 32'hBAD) begin failures++; $display("FAIL nowr_wbdata: got %h expected %h", wbData, 32'hBAD); end
    checks++; if (readData1 !== 32'h1234_5678) begin failures++; $display("FAIL nowr_no_bypass: got %h expected %h", readData1, 32'h1234_5678); end
    @(posedge clk); #1;
    wbIn = 2'b00; #1;
    checks++; if (readData1 !== 32'h1234_5678) begin failures++; $display("FAIL nowr_reg8_kept: got %h expected %h", readData1, 32'h1234_5678); end
    checks++; if (writeCount !== 32'd2) begin failures++; $display("FAIL nowr_count: got %0d expected 2", writeCount); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wbIn = 2'b10; registerRdIn = 5'(10 + i); resultIn = vals[i];
      readReg1 = 5'(10 + i); readReg2 = 5'd9; #1;
      checks++; if (readData1 !== vals[i]) begin failures++; $display("FAIL b2b_bypass%0d: got %h expected %h", i, readData1, vals[i]); end
      @(posedge clk);
    end
    #1;
    wbIn = 2'b00;
    for (int i = 0; i < 3; i++) begin
      readReg2 = 5'(10 + i); #1;
      checks++; if (readData2 !== vals[i]) begin failures++; $display("FAIL b2b_stored%0d: got %h expected %h", i, readData2, vals[i]); end
    end
    checks++; if (writeCount !== 32'd5) begin failures++; $display("FAIL b2b_count: got %0d expected 5", writeCount); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wbIn = 2'b10; registerRdIn = 5'd3; resultIn = 32'h77; readReg1 = 5'd3; readReg2 = 5'd8;
    @(posedge clk); #1;
    wbIn = 2'b00; #1;
    checks++; if (readData1 !== 32'h77) begin failures++; $display("FAIL mid_reg3_written: got %h expected %h", readData1, 32'h77); end
    checks++; if (writeCount !== 32'd6) begin failures++; $display("FAIL mid_count_before: got %0d expected 6", writeCount); end
    @(negedge clk);
    rst = 1'b0; wbIn = 2'b10; registerRdIn = 5'd3; resultIn = 32'h88; #1;
    checks++; if (wbEnable !== 1'b0) begin failures++; $display("FAIL mid_wbenable: got %b expected 0", wbEnable); end
    checks++; if (readData1 !== 32'h77) begin failures++; $display("FAIL mid_no_bypass: got %h expected %h", readData1, 32'h77); end
    @(posedge clk); #1;
    checks++; if (readData1 !== 32'h0) begin failures++; $display("FAIL mid_reg3_cleared: got %h expected %h", readData1, 32'h0); end
    checks++; if (readData2 !== 32'h0) begin failures++; $display("FAIL mid_reg8_cleared: got %h expected %h", readData2, 32'h0); end
    checks++; if (writeCount !== 32'd0) begin failures++; $display("FAIL mid_count_cleared: got %0d expected 0", writeCount); end
    @(negedge clk);
    rst = 1'b1; wbIn = 2'b00;
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    force dut.write_count = 32'hFFFF_FFFF;
    #1;
    release dut.write_count;
    #1;
    checks++; if (writeCount !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload: got %h expected %h", writeCount, 32'hFFFF_FFFF); end
    wbIn = 2'b10; registerRdIn = 5'd4; resultIn = 32'h44; readReg1 = 5'd4;
    @(posedge clk); #1;
    wbIn = 2'b00; #1;
    checks++; if (writeCount !== 32'h0) begin failures++; $display("FAIL wrap_count: got %h expected %h", writeCount, 32'h0); end
    checks++; if (readData1 !== 32'h44) begin failures++; $display("FAIL wrap_reg4: got %h expected %h", readData1, 32'h44); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; wbIn = 2'b00; readDataIn = '0; resultIn = '0;
    registerRdIn = '0; readReg1 = '0; readReg2 = '0;
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_reg0();
    test_no_write();
    test_back_to_back();
    test_reset_mid();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the pipeline: consumes the MEM/WB pipeline register outputs (WB control, memory read data, ALU result, destination register).
- Selects the write-back value and commits it into a 32-entry general-purpose register file.
- Serves two ID-stage read ports with same-cycle WB→ID bypass, so the register-file hazard needs no extra stall.
- Counts committed writes for verification and performance monitoring.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register index width
DEPTH, 32, number of registers (2**ADDR_W)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
wbIn  in  2  WB control: bit1 = regWrite, bit0 = memToReg
readDataIn  in  DATA_W  data-memory read data from MEM/WB
resultIn  in  DATA_W  ALU result from MEM/WB
registerRdIn  in  ADDR_W  destination register index from MEM/WB
readReg1  in  ADDR_W  ID-stage source index 1 (rs)
readReg2  in  ADDR_W  ID-stage source index 2 (rt)
readData1  out  DATA_W  value of readReg1, bypass applied
readData2  out  DATA_W  value of readReg2, bypass applied
wbData  out  DATA_W  selected write-back value (feeds EX forwarding)
wbEnable  out  1  qualified write strobe (feeds EX forwarding)
writeCount  out  32  number of committed register writes since reset

Behaviour:
- Reset: rst is sampled only on a rising clk edge.
  - rst=0 at an edge: all DEPTH registers clear to 0 and writeCount clears to 0 at that edge.
  - No write is committed on a reset edge, regardless of wbIn.
  - Reset asserted mid-stream discards the write presented in that cycle.
- Write-back select (combinational):
  - wbData = readDataIn when wbIn[0]=1, else resultIn.
- Write qualification (combinational):
  - wbEnable = wbIn[1] AND (registerRdIn != 0).
  - wbEnable is forced to 0 while rst=0.
- Commit: on a rising edge with rst=1 and wbEnable=1:
  - reg[registerRdIn] <= wbData.
  - writeCount <= writeCount + 1. The counter wraps modulo 2**32 (0xFFFFFFFF + 1 → 0).
- Register 0:
  - Never written; always reads 0.
  - A write to index 0 is ignored and does not increment writeCount.
- Read ports (combinational, zero latency):
  - readDataN = 0 if readRegN = 0.
  - Else readDataN = wbData if (wbEnable=1 and readRegN = registerRdIn).
  - Else readDataN = reg[readRegN].
- Bypass rules:
  - Both read ports may bypass the same write simultaneously.
  - Bypass is active only while rst=1.
- Reset outputs:
  - readData1/readData2 are 0 after any reset edge until the next committed write.
  - During rst=0 they still reflect register contents, which are 0 after the first reset edge.
  - wbData follows its inputs at all times.
- One write per cycle maximum. No internal stall and no handshake: every valid MEM/WB entry retires in the cycle it is presented.

Test Plan:
- Reset: hold rst=0 for 2 edges with wbIn=2'b10, registerRdIn=5, resultIn=0xDEAD → reg5 reads 0, writeCount=0, wbEnable=0.
- ALU write then read: wbIn=2'b10, registerRdIn=8, resultIn=0x1234_5678, one edge; then wbIn=0, readReg1=8 → readData1=0x1234_5678, writeCount=1.
- Load select and bypass: wbIn=2'b11, registerRdIn=9, readDataIn=0xCAFE_F00D, resultIn=0x1, readReg1=readReg2=9 in the same cycle before the edge → both read ports = 0xCAFE_F00D combinationally; after the edge reg9 holds 0xCAFE_F00D.
- Register 0: wbIn=2'b10, registerRdIn=0, resultIn=0xFFFF_FFFF, one edge → readData1 (readReg1=0) = 0, wbEnable=0, writeCount unchanged.
- No-write cycle: wbIn=2'b01, registerRdIn=8, readDataIn=0xBAD, one edge → reg8 keeps its prior value, wbEnable=0, no bypass on readReg1=8, writeCount unchanged.
- Reset mid-operation and counter wrap: write reg3=0x77 (one edge), then rst=0 with a valid write to reg3 → reg3=0, writeCount=0. Separately, force writeCount to 0xFFFF_FFFF through 2**32-1 writes or a bench-only preload, commit one write → writeCount=0.
